// File: rtl/lfsr_encrypter.sv
// lfsr_encrypter
//   Reads plaintext from a combinational-read memory, prepends pre_len copies of
//   a preamble char, XORs bits [4:0] of every char with a 5-bit maximal-length
//   LFSR keystream and writes the ciphertext back to memory.
//   Optional feature macro: ENCRYPTER_SEED_GUARD_EN (replaces a zero seed by
//   5'h1F and flags it on seed_fixed).
module lfsr_encrypter #(
  parameter logic [7:0] SRC_BASE = 8'd64,
  parameter logic [7:0] DST_BASE = 8'd0,
  parameter int         MSG_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] preamble,
  input  logic [3:0] pre_len,
  input  logic [2:0] tap_sel,
  input  logic [4:0] seed,
  output logic [7:0] mem_raddr,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic       busy,
  output logic       done,
  output logic       seed_fixed
);

  localparam logic [7:0] LAST_J = 8'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRE,
    S_MSG,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] lfsr_q;
  logic [4:0] lfsr_next;
  logic [3:0] k_q;
  logic [7:0] j_q;
  logic [7:0] preamble_q;
  logic [3:0] pre_len_q;
  logic [4:0] taps_q;
  logic [4:0] seed_q;
  logic [4:0] seed_eff;
  logic       seed_fixed_q;
  logic       start_ok;

  // Feedback polynomial per tap_sel; the two unused codes fall back to 5'h1E.
  function automatic logic [4:0] tap_mask(input logic [2:0] sel);
    case (sel)
      3'd1:    tap_mask = 5'h1D;
      3'd2:    tap_mask = 5'h1B;
      3'd3:    tap_mask = 5'h17;
      3'd4:    tap_mask = 5'h14;
      3'd5:    tap_mask = 5'h12;
      default: tap_mask = 5'h1E;
    endcase
  endfunction

  // A start pulse is only honoured between runs.
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign lfsr_next = {lfsr_q[3:0], ^(lfsr_q & taps_q)};

`ifdef ENCRYPTER_SEED_GUARD_EN
  // All-zero is the LFSR lock-up state, so a zero seed is replaced by all-ones.
  assign seed_eff = (seed == 5'd0) ? 5'h1F : seed;

  // Remember whether the current run had its seed replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_fixed_q <= 1'b0;
    end else if (start_ok) begin
      seed_fixed_q <= (seed == 5'd0);
    end
  end
`else
  assign seed_eff     = seed;
  assign seed_fixed_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Run configuration capture, LFSR and char counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preamble_q <= 8'd0;
      pre_len_q  <= 4'd0;
      taps_q     <= 5'd0;
      seed_q     <= 5'd0;
      lfsr_q     <= 5'd0;
      k_q        <= 4'd0;
      j_q        <= 8'd0;
    end else begin
      if (start_ok) begin
        preamble_q <= preamble;
        pre_len_q  <= pre_len;
        taps_q     <= tap_mask(tap_sel);
        seed_q     <= seed_eff;
      end
      case (state_q)
        S_LOAD: begin
          lfsr_q <= seed_q;
          k_q    <= 4'd0;
          j_q    <= 8'd0;
        end
        S_PRE: begin
          lfsr_q <= lfsr_next;
          k_q    <= k_q + 4'd1;
        end
        S_MSG: begin
          lfsr_q <= lfsr_next;
          j_q    <= j_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every combinationally assigned signal first is what
    // keeps a missing branch from inferring a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (pre_len_q != 4'd0) ? S_PRE : S_MSG;
      S_PRE:   if (k_q == pre_len_q - 4'd1) state_d = S_MSG;
      S_MSG:   if (j_q == LAST_J) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory interface and status outputs, forced to zero while reset is held.
  always_comb begin
    mem_raddr  = SRC_BASE;
    mem_waddr  = DST_BASE;
    mem_wr_en  = 1'b0;
    mem_wdata  = 8'd0;
    busy       = 1'b0;
    done       = 1'b0;
    seed_fixed = seed_fixed_q;
    case (state_q)
      S_LOAD: busy = 1'b1;
      S_PRE: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_waddr = DST_BASE + {4'd0, k_q};
        mem_wdata = {preamble_q[7:5], preamble_q[4:0] ^ lfsr_q};
      end
      S_MSG: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_raddr = SRC_BASE + j_q;
        mem_waddr = DST_BASE + {4'd0, pre_len_q} + j_q;
        mem_wdata = {mem_rdata[7:5], mem_rdata[4:0] ^ lfsr_q};
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
    // Asynchronous reset clears outputs immediately, not at the next edge.
    if (!rst_n) begin
      mem_raddr  = 8'd0;
      mem_waddr  = 8'd0;
      mem_wr_en  = 1'b0;
      mem_wdata  = 8'd0;
      busy       = 1'b0;
      done       = 1'b0;
      seed_fixed = 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_encrypter.sv
// tb_lfsr_encrypter
//   Randomized bench for lfsr_encrypter. Plaintext lives in one array that the
//   DUT reads combinationally; ciphertext lands in a second array. The expected
//   write stream comes from a char-by-char model of the keystream rules.
//   The source region wraps (F0..2F) and never overlaps the destination.
module tb_lfsr_encrypter;

  localparam logic [7:0] SRC = 8'hF0;
  localparam logic [7:0] DST = 8'h60;
  localparam int         ML  = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] preamble;
  logic [3:0] pre_len;
  logic [2:0] tap_sel;
  logic [4:0] seed;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       seed_fixed;

  logic [7:0]  plain [256];
  logic [7:0]  ct    [256];
  logic [15:0] cap_q [$];
  logic [15:0] exp_q [$];
  int          taps_tbl [8] = '{'h1E, 'h1D, 'h1B, 'h17, 'h14, 'h12, 'h1E, 'h1E};

  int vectors     = 0;
  int miscompares = 0;

  lfsr_encrypter #(
    .SRC_BASE(SRC),
    .DST_BASE(DST),
    .MSG_LEN (ML)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .preamble  (preamble),
    .pre_len   (pre_len),
    .tap_sel   (tap_sel),
    .seed      (seed),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .seed_fixed(seed_fixed)
  );

  always #5 clk = ~clk;

  assign mem_rdata = plain[mem_raddr];

  // Ciphertext memory commits on the rising edge.
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) ct[mem_waddr] <= mem_wdata;
  end

  // Record every pending write, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) cap_q.push_back({mem_waddr, mem_wdata});
  end

  // Keystream rule: shift left, new bit is parity of state AND taps.
  function automatic int next_key(input int l, input int t);
    int p = 0;
    for (int b = 0; b < 5; b++) p = p ^ (((l & t) >> b) & 1);
    return ((l * 2) % 32) + p;
  endfunction

  function automatic int eff_seed(input int sd);
`ifdef ENCRYPTER_SEED_GUARD_EN
    if (sd == 0) return 31;
`endif
    return sd;
  endfunction

  function automatic logic [7:0] enc(input int c, input int key);
    return 8'((c & 'hE0) | ((c ^ key) & 'h1F));
  endfunction

  // Expected (address, data) stream for a whole run.
  task automatic build_exp(input int pa, input int pl, input int tap, input int sd);
    int key = eff_seed(sd);
    exp_q.delete();
    for (int i = 0; i < pl; i++) begin
      exp_q.push_back({8'((DST + i) % 256), enc(pa, key)});
      key = next_key(key, tap);
    end
    for (int j = 0; j < ML; j++) begin
      exp_q.push_back({8'((DST + pl + j) % 256), enc(plain[(SRC + j) % 256], key)});
      key = next_key(key, tap);
    end
  endtask

  // Pulse start for one edge (E0); returns just after E0.
  task automatic launch(input logic [7:0] pa, input logic [3:0] pl,
                        input logic [2:0] ts, input logic [4:0] sd);
    @(negedge clk);
    preamble = pa;
    pre_len  = pl;
    tap_sel  = ts;
    seed     = sd;
    start    = 1'b1;
    cap_q.delete();
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after E0 until done; optionally re-pulse start mid-run.
  task automatic wait_done(input string name, input int exp_edges, input int pulse_at);
    int edges = 0;
    bit seen  = 0;
    while (!seen && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == pulse_at);
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    vectors++;
    if (!seen || edges != exp_edges) begin
      miscompares++;
      $display("FAIL %s done_latency got=%0d exp=%0d seen=%0d", name, edges, exp_edges, seen);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after_done got=%b exp=0", name, busy);
    end
  endtask

  task automatic check_writes(input string name);
    int n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    vectors++;
    if (cap_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d] got=%h exp=%h", name, i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) plain[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; preamble = 8'd0; pre_len = 4'd0; tap_sel = 3'd0; seed = 5'd0;
    fill_plain();
    #3;
    vectors++;
    if ({mem_raddr, mem_waddr, mem_wdata, mem_wr_en, busy, done, seed_fixed} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h/%h/%h/%b/%b/%b/%b exp=all0",
               mem_raddr, mem_waddr, mem_wdata, mem_wr_en, busy, done, seed_fixed);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_raddr !== SRC || mem_waddr !== DST || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_outputs raddr=%h waddr=%h wr=%b busy=%b exp=%h/%h/0/0",
               mem_raddr, mem_waddr, mem_wr_en, busy, SRC, DST);
    end
  endtask

  // Known vector plus a software decrypter over the produced ciphertext.
  task automatic test_known_and_decrypt();
    int rec_seed, rec_tap, key, bad;
    fill_plain();
    build_exp('h7E, 6, 'h1E, 'h0A);
    launch(8'h7E, 4'd6, 3'd0, 5'h0A);
    wait_done("known", 71, -1);
    check_writes("known");
    vectors++;
    if (ct[DST] !== 8'h74 || ct[DST + 8'd1] !== 8'h6A) begin
      miscompares++;
      $display("FAIL known_first_chars got=%h,%h exp=74,6A", ct[DST], ct[DST + 8'd1]);
    end
    rec_seed = int'(ct[DST][4:0]) ^ 'h1E;
    vectors++;
    if (rec_seed != 'h0A) begin
      miscompares++;
      $display("FAIL decrypt_seed got=%h exp=0a", rec_seed);
    end
    rec_tap = -1;
    for (int t = 0; t < 6 && rec_tap < 0; t++) begin
      key = rec_seed;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        if ((int'(ct[DST + 8'(i)]) ^ key) != 'h7E) bad++;
        key = next_key(key, taps_tbl[t]);
      end
      if (bad == 0) rec_tap = t;
    end
    vectors++;
    if (rec_tap != 0) begin
      miscompares++;
      $display("FAIL decrypt_tap got=%0d exp=0", rec_tap);
    end
    key = rec_seed;
    for (int i = 0; i < 6; i++) key = next_key(key, 'h1E);
    bad = 0;
    for (int j = 0; j < ML; j++) begin
      if ((ct[8'((DST + 6 + j) % 256)] ^ 8'(key)) !== plain[(SRC + j) % 256]) bad++;
      key = next_key(key, 'h1E);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL decrypt_plaintext bad_chars got=%0d exp=0", bad);
    end
  endtask

  task automatic test_no_preamble();
    fill_plain();
    build_exp(0, 0, 'h12, 'h01);
    launch(8'($urandom), 4'd0, 3'd5, 5'h01);
    wait_done("no_pre", ML + 1, -1);
    check_writes("no_pre");
    vectors++;
    if (ct[DST] !== {plain[SRC][7:5], plain[SRC][4:0] ^ 5'h01}) begin
      miscompares++;
      $display("FAIL no_pre_first got=%h exp=%h", ct[DST], {plain[SRC][7:5], plain[SRC][4:0] ^ 5'h01});
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] pa = 8'($urandom);
    logic [4:0] sd = 5'($urandom_range(1, 31));
    fill_plain();
    build_exp(pa, 3, 'h1B, sd);
    launch(pa, 4'd3, 3'd2, sd);
    wait_done("start_ignored", 68, 30);
    check_writes("start_ignored");
  endtask

  task automatic test_reset_mid();
    logic [7:0] pa = 8'($urandom);
    int n;
    fill_plain();
    build_exp(pa, 2, 'h17, 'h13);
    launch(pa, 4'd2, 3'd3, 5'h13);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_raddr, mem_waddr, mem_wdata, mem_wr_en, busy, done} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs wr=%b busy=%b raddr=%h waddr=%h exp=all0",
               mem_wr_en, busy, mem_raddr, mem_waddr);
    end
    n = cap_q.size();
    vectors++;
    if (n != 19) begin
      miscompares++;
      $display("FAIL reset_mid_prefix_len got=%0d exp=19", n);
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (cap_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_mid_write[%0d] got=%h exp=%h", i, cap_q[i], exp_q[i]);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (cap_q.size() != n || mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_writes got=%0d exp=%0d", cap_q.size(), n);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tap7();
    logic [7:0] pa = 8'($urandom);
    logic [4:0] sd = 5'($urandom_range(1, 31));
    fill_plain();
    build_exp(pa, 4, 'h1E, sd);
    launch(pa, 4'd4, 3'd7, sd);
    wait_done("tap7", 69, -1);
    check_writes("tap7");
  endtask

  task automatic test_seed_zero();
    logic [7:0] pa = 8'($urandom);
    logic [2:0] ts = 3'($urandom_range(0, 5));
    logic       exp_fix;
`ifdef ENCRYPTER_SEED_GUARD_EN
    exp_fix = 1'b1;
`else
    exp_fix = 1'b0;
`endif
    fill_plain();
    build_exp(pa, 5, taps_tbl[ts], 0);
    launch(pa, 4'd5, ts, 5'd0);
    vectors++;
    if (seed_fixed !== exp_fix) begin
      miscompares++;
      $display("FAIL seed_fixed_load got=%b exp=%b", seed_fixed, exp_fix);
    end
    wait_done("seed_zero", 70, -1);
    check_writes("seed_zero");
    vectors++;
    if (seed_fixed !== exp_fix) begin
      miscompares++;
      $display("FAIL seed_fixed_done got=%b exp=%b", seed_fixed, exp_fix);
    end
    if (!exp_fix) begin
      vectors++;
      if (ct[DST + 8'd5][4:0] !== plain[SRC][4:0]) begin
        miscompares++;
        $display("FAIL seed_zero_clear got=%h exp=%h", ct[DST + 8'd5][4:0], plain[SRC][4:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      logic [7:0] pa = 8'($urandom);
      logic [3:0] pl = 4'($urandom_range(0, 15));
      logic [2:0] ts = 3'($urandom_range(0, 7));
      logic [4:0] sd = 5'($urandom);
      fill_plain();
      build_exp(pa, pl, taps_tbl[ts], sd);
      launch(pa, pl, ts, sd);
      wait_done($sformatf("random%0d", r), 1 + int'(pl) + ML, -1);
      check_writes($sformatf("random%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_known_and_decrypt();
    test_no_preamble();
    test_start_ignored();
    test_reset_mid();
    test_tap7();
    test_seed_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
